// File: rtl/if_stage_pkg.sv
// Shared constants for the OpenMIPS fetch stage: word/bus widths,
// chip-enable and stall encodings, and the active-low reset level.
package if_stage_pkg;

   localparam int          INST_ADDR_W = 32;
   localparam int          INST_DATA_W = 32;

   localparam logic [31:0] ZeroWord    = 32'h0000_0000;

   localparam logic        ChipEnable  = 1'b1;
   localparam logic        ChipDisable = 1'b0;

   localparam logic        Stop        = 1'b1;
   localparam logic        NoStop      = 1'b0;

   // Reset is active-low: rst == RstEnable means "in reset".
   localparam logic        RstEnable   = 1'b0;

   // Sequential fetch advances one 32-bit word.
   localparam int          PC_STEP     = 4;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Flush always squashes; a stall of IF with ID
// running inserts a bubble; a stall of both IF and ID holds the contents.
// id_valid marks that id_inst is a real fetched instruction (no ready
// handshake: downstream stalls are expressed through the stall vector).
module if_stage_if_id_reg
   import if_stage_pkg::*;
#(
   parameter int ADDR_W  = INST_ADDR_W,
   parameter int INST_W  = INST_DATA_W,
   parameter int STALL_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  if_pc,
   input  logic [INST_W-1:0]  if_inst,
   input  logic               if_valid,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [INST_W-1:0]  id_inst,
   output logic               id_valid
);

   // Register update: flush > bubble > hold > capture.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         id_pc    <= '0;
         id_inst  <= INST_W'(ZeroWord);
         id_valid <= 1'b0;
      end else if (flush) begin
         id_pc    <= '0;
         id_inst  <= INST_W'(ZeroWord);
         id_valid <= 1'b0;
      end else if (stall[1] == Stop && stall[2] == NoStop) begin
         id_pc    <= '0;
         id_inst  <= INST_W'(ZeroWord);
         id_valid <= 1'b0;
      end else if (stall[1] == Stop) begin
         id_pc    <= id_pc;
         id_inst  <= id_inst;
         id_valid <= id_valid;
      end else begin
         id_pc    <= if_pc;
         id_inst  <= if_inst;
         id_valid <= if_valid;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and ROM chip enable, addresses the
// instruction ROM directly from the PC, and hands the fetched word to ID
// through the IF/ID register. Branches keep their delay slot; only an
// exception flush squashes the instruction already in IF/ID.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int              ADDR_W   = INST_ADDR_W,
   parameter int              INST_W   = INST_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  new_pc,
   output logic               rom_ce_o,
   output logic [ADDR_W-1:0]  rom_addr_o,
   input  logic [INST_W-1:0]  rom_inst_i,
   output logic [ADDR_W-1:0]  id_pc_o,
   output logic [INST_W-1:0]  id_inst_o,
   output logic               id_valid_o
);

   logic [ADDR_W-1:0] pc;

   // Chip enable rises on the first edge after reset release and stays up.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         rom_ce_o <= ChipDisable;
      end else begin
         rom_ce_o <= ChipEnable;
      end
   end

   // PC update: disabled > flush > stall hold > branch > sequential (wraps).
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         pc <= RESET_PC;
      end else if (rom_ce_o == ChipDisable) begin
         pc <= RESET_PC;
      end else if (flush) begin
         pc <= new_pc;
      end else if (stall[0] == Stop) begin
         pc <= pc;
      end else if (branch_flag_i) begin
         pc <= branch_target_i;
      end else begin
         pc <= pc + ADDR_W'(PC_STEP);
      end
   end

   assign rom_addr_o = pc;

   if_stage_if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INST_W  (INST_W),
      .STALL_W (STALL_W)
   ) u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .flush    (flush),
      .if_pc    (pc),
      .if_inst  (rom_inst_i),
      .if_valid (rom_ce_o),
      .id_pc    (id_pc_o),
      .id_inst  (id_inst_o),
      .id_valid (id_valid_o)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. A combinational ROM model returns
// 32'hC0DE_0000 ^ address while enabled and zero otherwise; every expected
// ROM word below is written out by hand from that rule.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        flush;
   logic [31:0] new_pc;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_inst_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;

   int checks;
   int errors;

   logic [64:0] got_id;
   logic [64:0] exp_id;

   if_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .flush           (flush),
      .new_pc          (new_pc),
      .rom_ce_o        (rom_ce_o),
      .rom_addr_o      (rom_addr_o),
      .rom_inst_i      (rom_inst_i),
      .id_pc_o         (id_pc_o),
      .id_inst_o       (id_inst_o),
      .id_valid_o      (id_valid_o)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign rom_inst_i = rom_ce_o ? (32'hC0DE_0000 ^ rom_addr_o) : 32'h0;

   // Advance one rising edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset pulse followed by three clean edges: leaves pc=8, IF/ID=(4,B,1).
   task automatic bring_up();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
      flush = 1'b0; new_pc = '0;
      step();
      step();
      checks++;
      if ({rom_ce_o, rom_addr_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL reset_rom: got ce=%b addr=%h required ce=0 addr=0", rom_ce_o, rom_addr_o);
      end
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h0, 32'h0, 1'b0};
      checks++;
      if (got_id !== exp_id) begin
         errors++; $display("FAIL reset_id: got %h required %h", got_id, exp_id);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL first_fetch: got ce=%b addr=%h required ce=1 addr=0", rom_ce_o, rom_addr_o);
      end
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h0, 32'h0, 1'b0};
      checks++;
      if (got_id !== exp_id) begin
         errors++; $display("FAIL first_fetch_id: got %h required %h", got_id, exp_id);
      end
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h0, 32'hC0DE_0000, 1'b1};
      checks++;
      if (rom_addr_o !== 32'h4 || got_id !== exp_id) begin
         errors++; $display("FAIL seq_A: got addr=%h id=%h required addr=4 id=%h", rom_addr_o, got_id, exp_id);
      end
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h4, 32'hC0DE_0004, 1'b1};
      checks++;
      if (rom_addr_o !== 32'h8 || got_id !== exp_id) begin
         errors++; $display("FAIL seq_B: got addr=%h id=%h required addr=8 id=%h", rom_addr_o, got_id, exp_id);
      end
   endtask

   task automatic test_stall_bubble();
      stall = 6'b000011;
      for (int i = 0; i < 2; i++) begin
         step();
         got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h0, 32'h0, 1'b0};
         checks++;
         if (rom_addr_o !== 32'h8 || got_id !== exp_id) begin
            errors++; $display("FAIL bubble_%0d: got addr=%h id=%h required addr=8 id=%h", i, rom_addr_o, got_id, exp_id);
         end
      end
      stall = 6'b000000;
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h8, 32'hC0DE_0008, 1'b1};
      checks++;
      if (rom_addr_o !== 32'hC || got_id !== exp_id) begin
         errors++; $display("FAIL bubble_resume: got addr=%h id=%h required addr=c id=%h", rom_addr_o, got_id, exp_id);
      end
   endtask

   task automatic test_stall_hold();
      bring_up();
      stall = 6'b000111;
      for (int i = 0; i < 2; i++) begin
         step();
         got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h4, 32'hC0DE_0004, 1'b1};
         checks++;
         if (rom_addr_o !== 32'h8 || got_id !== exp_id) begin
            errors++; $display("FAIL hold_%0d: got addr=%h id=%h required addr=8 id=%h", i, rom_addr_o, got_id, exp_id);
         end
      end
      stall = 6'b000000;
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h8, 32'hC0DE_0008, 1'b1};
      checks++;
      if (rom_addr_o !== 32'hC || got_id !== exp_id) begin
         errors++; $display("FAIL hold_resume: got addr=%h id=%h required addr=c id=%h", rom_addr_o, got_id, exp_id);
      end
   endtask

   task automatic test_branch();
      // pc=12 here; the delay slot at 12 must still reach ID.
      branch_flag_i = 1'b1; branch_target_i = 32'h100;
      step();
      branch_flag_i = 1'b0;
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'hC, 32'hC0DE_000C, 1'b1};
      checks++;
      if (rom_addr_o !== 32'h100 || got_id !== exp_id) begin
         errors++; $display("FAIL branch_slot: got addr=%h id=%h required addr=100 id=%h", rom_addr_o, got_id, exp_id);
      end
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h100, 32'hC0DE_0100, 1'b1};
      checks++;
      if (rom_addr_o !== 32'h104 || got_id !== exp_id) begin
         errors++; $display("FAIL branch_target: got addr=%h id=%h required addr=104 id=%h", rom_addr_o, got_id, exp_id);
      end
      // PC stall beats a pending branch; ID keeps the request up.
      stall = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'h200;
      step();
      checks++;
      if (rom_addr_o !== 32'h104) begin
         errors++; $display("FAIL branch_stalled: got addr=%h required addr=104", rom_addr_o);
      end
      stall = 6'b000000;
      step();
      branch_flag_i = 1'b0;
      checks++;
      if (rom_addr_o !== 32'h200) begin
         errors++; $display("FAIL branch_after_stall: got addr=%h required addr=200", rom_addr_o);
      end
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h200, 32'hC0DE_0200, 1'b1};
      checks++;
      if (rom_addr_o !== 32'h204 || got_id !== exp_id) begin
         errors++; $display("FAIL branch_after_stall_id: got addr=%h id=%h required addr=204 id=%h", rom_addr_o, got_id, exp_id);
      end
   endtask

   task automatic test_flush();
      flush = 1'b1; new_pc = 32'h20; branch_flag_i = 1'b1; branch_target_i = 32'h100;
      step();
      flush = 1'b0; branch_flag_i = 1'b0;
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h0, 32'h0, 1'b0};
      checks++;
      if (rom_addr_o !== 32'h20 || got_id !== exp_id) begin
         errors++; $display("FAIL flush_over_branch: got addr=%h id=%h required addr=20 id=%h", rom_addr_o, got_id, exp_id);
      end
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h20, 32'hC0DE_0020, 1'b1};
      checks++;
      if (rom_addr_o !== 32'h24 || got_id !== exp_id) begin
         errors++; $display("FAIL flush_resume: got addr=%h id=%h required addr=24 id=%h", rom_addr_o, got_id, exp_id);
      end
      // Flush also overrides a full IF/ID stall.
      flush = 1'b1; new_pc = 32'h40; stall = 6'b000111;
      step();
      flush = 1'b0; stall = 6'b000000;
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h0, 32'h0, 1'b0};
      checks++;
      if (rom_addr_o !== 32'h40 || got_id !== exp_id) begin
         errors++; $display("FAIL flush_over_stall: got addr=%h id=%h required addr=40 id=%h", rom_addr_o, got_id, exp_id);
      end
   endtask

   task automatic test_wrap();
      flush = 1'b1; new_pc = 32'hFFFF_FFFC;
      step();
      flush = 1'b0;
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'hFFFF_FFFC, 32'h3F21_FFFC, 1'b1};
      checks++;
      if (rom_addr_o !== 32'h0 || got_id !== exp_id) begin
         errors++; $display("FAIL wrap: got addr=%h id=%h required addr=0 id=%h", rom_addr_o, got_id, exp_id);
      end
      // Low address bits are carried through untouched.
      flush = 1'b1; new_pc = 32'h42;
      step();
      flush = 1'b0;
      step();
      checks++;
      if (rom_addr_o !== 32'h46) begin
         errors++; $display("FAIL unaligned: got addr=%h required addr=46", rom_addr_o);
      end
   endtask

   task automatic test_mid_reset();
      step();
      #2;
      rst = 1'b0;
      #1;
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h0, 32'h0, 1'b0};
      checks++;
      if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || got_id !== exp_id) begin
         errors++; $display("FAIL async_reset: got ce=%b addr=%h id=%h required ce=0 addr=0 id=%h", rom_ce_o, rom_addr_o, got_id, exp_id);
      end
      step();
      rst = 1'b1;
      step();
      step();
      got_id = {id_pc_o, id_inst_o, id_valid_o}; exp_id = {32'h0, 32'hC0DE_0000, 1'b1};
      checks++;
      if (rom_addr_o !== 32'h4 || got_id !== exp_id) begin
         errors++; $display("FAIL reset_recover: got addr=%h id=%h required addr=4 id=%h", rom_addr_o, got_id, exp_id);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_stall_bubble();
      test_stall_hold();
      test_branch();
      test_flush();
      test_wrap();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the OpenMIPS pipeline.
- Generates the PC and drives chip-enable and address to the instruction ROM.
- Samples the ROM's combinational instruction output into the IF/ID pipeline register for the decode stage.
- Handles pipeline stall, branch redirect and exception flush (new_pc).

Parameters:
- ADDR_W, 32, PC / ROM address width
- INST_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- STALL_W, 6, width of the global stall vector (bit0 PC, bit1 IF, bit2 ID, ...)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  STALL_W  global stall vector from stall controller
- branch_flag_i  in  1  redirect request from ID this cycle
- branch_target_i  in  ADDR_W  redirect address
- flush  in  1  exception flush from CP0/ctrl
- new_pc  in  ADDR_W  exception handler address, valid with flush
- rom_ce_o  out  1  ROM chip enable (ChipEnable/ChipDisable)
- rom_addr_o  out  ADDR_W  ROM byte address (= PC)
- rom_inst_i  in  INST_W  instruction from ROM (combinational from rom_ce_o/rom_addr_o)
- id_pc_o  out  ADDR_W  PC of instruction presented to ID
- id_inst_o  out  INST_W  instruction presented to ID
- id_valid_o  out  1  id_inst_o holds a real fetched instruction

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, also mid-operation):
  - pc=RESET_PC, rom_ce_o=0
  - id_pc_o=0, id_inst_o=ZeroWord, id_valid_o=0
- Chip enable:
  - rom_ce_o is a register; it becomes 1 on the first rising edge after rst deasserts and stays 1.
  - While rom_ce_o=0, pc is held at RESET_PC.
  - First fetch therefore addresses RESET_PC one cycle after reset release.
- rom_addr_o = pc, combinational, no extra latency.
- PC next-state priority, evaluated each edge:
  1. rom_ce_o=0 -> RESET_PC
  2. flush -> new_pc
  3. stall[0] -> hold
  4. branch_flag_i -> branch_target_i
  5. otherwise -> pc+4, modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0
- flush and branch_flag_i together: flush wins.
- stall[0] and branch_flag_i together: hold wins. ID keeps branch_flag_i asserted until the stall clears.
- PC bits [1:0] pass through unmodified. Alignment checking is not this block's job.
- IF/ID register, priority each edge:
  1. flush -> id_pc_o=0, id_inst_o=ZeroWord, id_valid_o=0
  2. stall[1]=1 and stall[2]=0 -> bubble: same zero/invalid values
  3. stall[1]=1 and stall[2]=1 -> hold all three
  4. otherwise -> id_pc_o=pc, id_inst_o=rom_inst_i, id_valid_o=rom_ce_o
- Latency: the instruction at PC p appears on id_inst_o exactly one edge after rom_addr_o=p, absent stall or flush.
- Branch delay slot:
  - The instruction fetched in the cycle branch_flag_i is high is captured normally into IF/ID; it is not squashed.
  - The target is fetched the following cycle.
- Only flush squashes IF/ID. No internal state besides pc, ce, and the IF/ID register.

Decomposition:
- Shared defines file (existing):
  - ZeroWord
  - InstAddrBus / InstBus ranges
  - ChipEnable / ChipDisable
  - Stop / NoStop
  - RstEnable: value 1'b0 for the active-low reset
- One natural sub-module: if_id_reg, holding the IF/ID register and its flush/stall/bubble logic.
- PC and ce logic stays in the if_stage top.

Test Plan:
- Reset release, no stall:
  - Expect rom_ce_o=0 then 1, rom_addr_o=0,4,8,…
  - With ROM words A,B,C, id_inst_o=A,B,C on successive cycles with id_pc_o=0,4,8 and id_valid_o=1.
- stall=6'b000011 for 2 cycles at pc=8:
  - rom_addr_o holds 8.
  - id_inst_o becomes ZeroWord with id_valid_o=0 (bubble).
  - Fetch resumes at 8, then 12.
- stall=6'b000111 at pc=8:
  - IF/ID holds previous (pc=4, B, valid=1).
  - No bubble inserted.
- branch_flag_i=1, target=32'h100 while pc=12:
  - Delay slot at 12 reaches ID.
  - Next rom_addr_o=32'h100.
  - Then id_pc_o=12, followed by id_pc_o=32'h100.
- flush=1, new_pc=32'h20 with branch_flag_i=1, target=32'h100:
  - Next rom_addr_o=32'h20.
  - IF/ID cleared to 0/ZeroWord/valid=0.
- Wrap and mid-operation reset:
  - Force pc=32'hFFFF_FFFC; next pc=0.
  - Assert rst=0 between edges: all outputs clear immediately without a clock.
